// File: rtl/chess_pkg.sv
// ---------------------------------------------------------------------------
// chess_pkg
// Shared definitions for the MVV-LVA move sorter: piece codes, move-word
// field offsets, move/key widths, the sorter FSM state type and small field
// extraction helpers.
// Move word (18 bits):
//   {from_x[2:0], from_y[2:0], to_x[2:0], to_y[2:0], attacker[2:0], victim[2:0]}
// ---------------------------------------------------------------------------
package chess_pkg;

  localparam int MOVE_W  = 18;
  localparam int KEY_W   = 6;
  localparam int PIECE_W = 3;

  // Piece codes
  localparam logic [PIECE_W-1:0] PIECE_EMPTY  = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_PAWN   = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_KNIGHT = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_BISHOP = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_ROOK   = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_QUEEN  = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_KING   = 3'd6;

  // Least-significant bit of each 3-bit field in the move word
  localparam int FROM_X_LSB   = 15;
  localparam int FROM_Y_LSB   = 12;
  localparam int TO_X_LSB     = 9;
  localparam int TO_Y_LSB     = 6;
  localparam int ATTACKER_LSB = 3;
  localparam int VICTIM_LSB   = 0;

  typedef logic [MOVE_W-1:0] move_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_EMIT    = 2'd2
  } sorter_state_e;

  function automatic logic [PIECE_W-1:0] move_victim(input move_t m);
    return m[VICTIM_LSB +: PIECE_W];
  endfunction

  function automatic logic [PIECE_W-1:0] move_attacker(input move_t m);
    return m[ATTACKER_LSB +: PIECE_W];
  endfunction

endpackage

// File: rtl/mvv_lva_sorter_if.sv
// ---------------------------------------------------------------------------
// mvv_lva_sorter_if
// Handshake bundle between the move generator, the sorter and the consumer.
//   in_valid/in_ready/in_move/in_last : move stream into the sorter
//   out_valid/out_ready/out_move/out_key : best-first move stream out
// Modports:
//   master : the environment (generator + consumer)
//   slave  : the sorter
// ---------------------------------------------------------------------------
interface mvv_lva_sorter_if;
  import chess_pkg::*;

  logic  in_valid;
  logic  in_ready;
  move_t in_move;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  move_t out_move;
  key_t  out_key;

  modport master (
    output in_valid, in_move, in_last, out_ready,
    input  in_ready, out_valid, out_move, out_key
  );

  modport slave (
    input  in_valid, in_move, in_last, out_ready,
    output in_ready, out_valid, out_move, out_key
  );

endinterface

// File: rtl/mvv_lva_key.sv
// ---------------------------------------------------------------------------
// mvv_lva_key
// Combinational MVV-LVA key: {victim, 7 - attacker}. Most valuable victim
// dominates; among equal victims the least valuable attacker wins.
//   move : 18-bit move word
//   key  : 6-bit unsigned key, larger is better
// ---------------------------------------------------------------------------
module mvv_lva_key
  import chess_pkg::*;
(
  input  move_t move,
  output key_t  key
);

  assign key = {move_victim(move), 3'd7 - move_attacker(move)};

endmodule

// File: rtl/mvv_lva_sorter.sv
// ---------------------------------------------------------------------------
// mvv_lva_sorter
// Buffers the moves of one position, then repeatedly scans the buffer for the
// highest MVV-LVA key and emits that move until the buffer is empty.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : mvv_lva_sorter_if.slave (in_* move stream, out_* best move)
//   abort  : synchronous discard of all buffered moves
//   count  : number of buffered moves
//   done   : one-cycle pulse when a position's move list is exhausted
// Parameter DEPTH: buffer slots, power of two in 2..64.
// Build option SORTER_CAPTURE_ONLY_EN: moves whose victim is EMPTY are
// accepted but not stored; in_last on such a move still ends collection.
// ---------------------------------------------------------------------------
module mvv_lva_sorter
  import chess_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mvv_lva_sorter_if.slave        bus,
  input  logic                   abort,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  sorter_state_e    state, state_next;

  move_t            slot_move [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    best_idx;
  key_t             best_key;
  logic             have_best;
  logic [IW-1:0]    emit_idx;
  move_t            out_move_q;
  key_t             out_key_q;

  logic             in_fire;
  logic             out_fire;
  logic             store;
  logic [CW-1:0]    count_after_store;
  move_t            scan_move;
  key_t             scan_key;
  logic             cand_better;
  logic [IW-1:0]    pick_idx;
  key_t             pick_key;

  assign bus.in_ready  = (state == ST_COLLECT) && (count < FULL);
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.out_move  = out_move_q;
  assign bus.out_key   = out_key_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

`ifdef SORTER_CAPTURE_ONLY_EN
  assign store = in_fire && (move_victim(bus.in_move) != PIECE_EMPTY);
`else
  assign store = in_fire;
`endif

  assign count_after_store = count + CW'(store);

  // Scan comparator: one slot per cycle against the running best. Strict
  // greater-than keeps the earliest-arrived move on equal keys.
  assign scan_move = slot_move[scan_idx];

  mvv_lva_key u_scan_key (
    .move (scan_move),
    .key  (scan_key)
  );

  assign cand_better = slot_valid[scan_idx] && (!have_best || (scan_key > best_key));
  assign pick_idx    = cand_better ? scan_idx : best_idx;
  assign pick_key    = cand_better ? scan_key : best_key;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_COLLECT;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so every path drives state_next; a missed
    // branch would otherwise infer a latch.
    state_next = state;
    case (state)
      ST_COLLECT: begin
        // An in_last that leaves the buffer empty ends the position at once.
        if (in_fire && bus.in_last && (count_after_store != '0))
          state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_idx == LAST_IDX) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_fire) state_next = (count == CW'(1)) ? ST_COLLECT : ST_SCAN;
      end
      default: state_next = ST_COLLECT;
    endcase
    if (abort) state_next = ST_COLLECT;
  end

  // Control and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      count      <= '0;
      slot_valid <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_key   <= '0;
      have_best  <= 1'b0;
      emit_idx   <= '0;
      out_move_q <= '0;
      out_key_q  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        count      <= '0;
        slot_valid <= '0;
        scan_idx   <= '0;
        have_best  <= 1'b0;
      end else begin
        case (state)
          ST_COLLECT: begin
            if (in_fire) begin
              if (store) begin
                slot_valid[count[IW-1:0]] <= 1'b1;
                count                     <= count_after_store;
              end
              if (bus.in_last) begin
                scan_idx  <= '0;
                have_best <= 1'b0;
                if (count_after_store == '0) done <= 1'b1;
              end
            end
          end
          ST_SCAN: begin
            scan_idx  <= scan_idx + 1'b1;
            best_idx  <= pick_idx;
            best_key  <= pick_key;
            have_best <= have_best || cand_better;
            if (scan_idx == LAST_IDX) begin
              emit_idx   <= pick_idx;
              out_move_q <= slot_move[pick_idx];
              out_key_q  <= pick_key;
            end
          end
          ST_EMIT: begin
            if (bus.out_ready) begin
              slot_valid[emit_idx] <= 1'b0;
              count                <= count - CW'(1);
              scan_idx             <= '0;
              have_best            <= 1'b0;
              if (count == CW'(1)) done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the move storage has no reset; slot_valid alone decides whether a
  // slot holds a live move, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (store && !abort) slot_move[count[IW-1:0]] <= bus.in_move;
  end

endmodule

// File: tb/tb_mvv_lva_sorter.sv
// ---------------------------------------------------------------------------
// tb_mvv_lva_sorter
// Scoreboard bench for mvv_lva_sorter. Stimulus pushes expected outputs
// (from a sort-by-key reference model or literal values) into a queue; an
// independent monitor compares every output handshake and counts done pulses.
// Honours SORTER_CAPTURE_ONLY_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mvv_lva_sorter;
  import chess_pkg::*;

  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int BUDGET = DEPTH * (DEPTH + 4) * 8 + 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] count;
  logic          done;

  mvv_lva_sorter_if bus ();

  mvv_lva_sorter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .abort (abort),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    move_t move;
    key_t  key;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;
  int   ready_mode   = 0;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic key_t ref_key(input move_t m);
    int v;
    int a;
    v = int'(m[2:0]);
    a = int'(m[5:3]);
    return key_t'(v * 8 + (7 - a));
  endfunction

  function automatic bit ref_stores(input move_t m);
`ifdef SORTER_CAPTURE_ONLY_EN
    return m[2:0] != 3'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Best key first; on equal keys the earlier move comes first.
  task automatic model_position(input move_t moves[$]);
    move_t kept[$];
    int    bi;
    foreach (moves[i]) if (ref_stores(moves[i])) kept.push_back(moves[i]);
    while (kept.size() > 0) begin
      bi = 0;
      for (int i = 1; i < kept.size(); i++)
        if (ref_key(kept[i]) > ref_key(kept[bi])) bi = i;
      sb.push_back('{kept[bi], ref_key(kept[bi])});
      kept.delete(bi);
    end
  endtask

  function automatic move_t mk(input int a, input int v);
    move_t m;
    m      = move_t'($urandom);
    m[5:3] = 3'(a);
    m[2:0] = 3'(v);
    return m;
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin : ready_driver
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t  e;
    move_t held_move;
    key_t  held_key;
    bit    holding;
    bit    prev_done;
    holding   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = done;
      if (holding && bus.out_valid) begin
        check("out_move_stable", 32'(bus.out_move), 32'(held_move));
        check("out_key_stable", 32'(bus.out_key), 32'(held_key));
      end
      holding   = bus.out_valid && !bus.out_ready && !abort;
      held_move = bus.out_move;
      held_key  = bus.out_key;
      if (bus.out_valid && bus.out_ready && !abort && rst_n) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_output: got move 0x%0h key 0x%0h, expected no output",
                   bus.out_move, bus.out_key);
        end else begin
          e = sb.pop_front();
          check("out_move", 32'(bus.out_move), 32'(e.move));
          check("out_key", 32'(bus.out_key), 32'(e.key));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input move_t m, input logic last);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_move  = m;
    bus.in_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("push_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int prev, input string name);
    int n;
    n = 0;
    while (done_cnt == prev && n < BUDGET) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, 32'(done_cnt), 32'(prev + 1));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_position(input move_t moves[$], input int mode, input string name);
    int prev;
    ready_mode = mode;
    prev       = done_cnt;
    model_position(moves);
    foreach (moves[i]) push(moves[i], i == moves.size() - 1);
    wait_done(prev, name);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    move_t q[$];
    move_t pxn, qxp, rxq;
    int    prev;
    int    n;
    bit    flag_a, flag_b;

    bus.in_valid = 1'b0;
    bus.in_move  = '0;
    bus.in_last  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_move", 32'(bus.out_move), 32'd0);
    check("rst_out_key", 32'(bus.out_key), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed PxN, QxP, RxQ with literal keys and DEPTH-cycle latency
    ready_mode = 0;
    pxn = mk(1, 2);
    qxp = mk(5, 1);
    rxq = mk(4, 5);
    sb.push_back('{rxq, 6'h2B});
    sb.push_back('{pxn, 6'h16});
    sb.push_back('{qxp, 6'h0A});
    prev = done_cnt;
    push(pxn, 1'b0);
    push(qxp, 1'b0);
    check("count_after_two", 32'(count), 32'd2);
    push(rxq, 1'b1);
    check("in_ready_scan", 32'(bus.in_ready), 32'd0);
    flag_a = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) flag_a = 1'b1;
    end
    check("out_valid_early", 32'(flag_a), 32'd0);
    @(posedge clk);
    #1;
    check("out_valid_at_depth", 32'(bus.out_valid), 32'd1);
    check("in_ready_emit", 32'(bus.in_ready), 32'd0);
    ready_mode = 1;
    wait_done(prev, "directed_done");

    // Tie on key 0x16: earlier move first
    q = '{};
    pxn = mk(1, 2);
    qxp = pxn ^ 18'h08000;
    q.push_back(pxn);
    q.push_back(qxp);
    q.push_back(mk(1, 1));
    run_position(q, 2, "tie_done");

    // Randomized positions
    for (int p = 0; p < 12; p++) begin
      q = '{};
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) q.push_back(mk($urandom_range(1, 6), $urandom_range(0, 5)));
`ifdef SORTER_CAPTURE_ONLY_EN
      q[0][2:0] = 3'(1 + p % 5);
`endif
      run_position(q, 2, "random_done");
    end

    // Full buffer without in_last
    ready_mode = 1;
    prev = done_cnt;
    for (int i = 0; i < DEPTH; i++) push(mk($urandom_range(1, 6), $urandom_range(1, 5)), 1'b0);
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_move  = mk(1, 5);
    flag_a = 1'b0;
    flag_b = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.in_ready) flag_a = 1'b1;
      if (bus.out_valid) flag_b = 1'b1;
    end
    check("full_no_accept", 32'(flag_a), 32'd0);
    check("full_no_out_valid", 32'(flag_b), 32'd0);
    check("full_count_held", 32'(count), 32'(DEPTH));
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("abort_full_count", 32'(count), 32'd0);
    check("abort_full_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_full_no_done", 32'(done_cnt), 32'(prev));

    // Abort wins over a simultaneous input handshake
    prev = done_cnt;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_move  = mk(2, 4);
    abort        = 1'b1;
    @(posedge clk);
    #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("abort_in_count", 32'(count), 32'd0);
    check("abort_in_collect", 32'(bus.in_ready), 32'd1);
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    check("abort_in_no_done", 32'(done_cnt), 32'(prev));

    // Abort mid-EMIT after a 10-cycle stall, together with out_ready
    ready_mode = 0;
    prev = done_cnt;
    push(mk(1, 2), 1'b0);
    push(mk(5, 1), 1'b0);
    push(mk(4, 5), 1'b1);
    n = 0;
    while (!bus.out_valid && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("stall_still_valid", 32'(bus.out_valid), 32'd1);
    ready_mode = 1;
    abort      = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_emit_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_emit_count", 32'(count), 32'd0);
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    check("abort_emit_no_done", 32'(done_cnt), 32'(prev));

    // Reset during SCAN
    ready_mode = 1;
    prev = done_cnt;
    push(mk(3, 4), 1'b0);
    push(mk(2, 3), 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("scan_rst_count", 32'(count), 32'd0);
    check("scan_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("scan_rst_done", 32'(done), 32'd0);
    check("scan_rst_out_move", 32'(bus.out_move), 32'd0);
    check("scan_rst_out_key", 32'(bus.out_key), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("scan_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (DEPTH + 4) @(posedge clk);
    #1;
    check("scan_rst_no_done", 32'(done_cnt), 32'(prev));

`ifdef SORTER_CAPTURE_ONLY_EN
    // Quiet move with in_last: accepted, not stored, position ends
    ready_mode = 1;
    prev = done_cnt;
    push(mk(2, 0), 1'b1);
    check("quiet_count", 32'(count), 32'd0);
    wait_done(prev, "quiet_done");
`endif

    // One more random position after all the disruptions
    q = '{};
    for (int i = 0; i < DEPTH; i++) q.push_back(mk($urandom_range(1, 6), $urandom_range(1, 5)));
    run_position(q, 2, "final_done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
